// File: rtl/sweep_scheduler.sv
// Frequency-sweep sequencer: settle, N averaged measurements per point, FIFO of records.
// Optional SWEEP_TIMEOUT_EN adds a meas_done watchdog that stores an error sentinel.
module sweep_scheduler #(
  parameter int ADDR_WIDTH     = 8,
  parameter int RES_WIDTH      = 32,
  parameter int AVG_LOG2       = 2,
  parameter int SETTLE_CYCLES  = 1250,
  parameter int FIFO_DEPTH     = 16
`ifdef SWEEP_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
  input  logic                  clk125,
  input  logic                  areset_n,
  input  logic                  sweep_start,
  input  logic                  sweep_abort,
  input  logic [ADDR_WIDTH-1:0] first_pt,
  input  logic [ADDR_WIDTH-1:0] last_pt,
  output logic                  meas_req,
  output logic [ADDR_WIDTH-1:0] meas_addr,
  input  logic                  meas_done,
  input  logic [RES_WIDTH-1:0]  meas_mod,
  input  logic [RES_WIDTH-1:0]  meas_phase,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [RES_WIDTH-1:0]  res_mod,
  output logic [RES_WIDTH-1:0]  res_phase,
  output logic                  busy,
  output logic                  sweep_done
);

  localparam int ACC_W = RES_WIDTH + AVG_LOG2;
  localparam int REP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [REP_W-1:0] REP_LAST =
    REP_W'((1 << AVG_LOG2) - 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(SETTLE_CYCLES - 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT =
    (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_REQ, S_WAIT, S_STORE, S_DONE
  } state_t;

  state_t state, state_d;
  logic start_q, start_edge;
  logic [ADDR_WIDTH-1:0] addr_q, last_q;
  logic signed [ACC_W-1:0] acc_mod, acc_ph;
  logic [REP_W-1:0] rep;
  logic [SET_W-1:0] set_cnt;
  logic acc_en, push, pop, full;
  logic [RES_WIDTH-1:0] push_mod, push_ph;

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [RES_WIDTH-1:0]  mem_mod  [FIFO_DEPTH];
  logic [RES_WIDTH-1:0]  mem_ph   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;

`ifdef SWEEP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd;
  logic to_hit, to_flag;
`endif

  assign start_edge = sweep_start & ~start_q;
  assign full       = (cnt == FULL_CNT);
  assign res_valid  = (cnt != '0);
  assign pop        = res_valid & res_ready;
  assign meas_addr  = addr_q;
  assign sweep_done = (state == S_DONE);
  assign busy       = (state == S_SETTLE) || (state == S_REQ) ||
                      (state == S_WAIT)   || (state == S_STORE);

  always_comb begin
    push_mod = RES_WIDTH'(acc_mod >>> AVG_LOG2);
    push_ph  = RES_WIDTH'(acc_ph >>> AVG_LOG2);
`ifdef SWEEP_TIMEOUT_EN
    if (to_flag) begin
      push_mod = {1'b0, {(RES_WIDTH-1){1'b1}}};
      push_ph  = '0;
    end
`endif
  end

  always_comb begin
    state_d  = state;
    meas_req = 1'b0;
    acc_en   = 1'b0;
    push     = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
    to_hit   = 1'b0;
`endif
    unique case (state)
      S_IDLE:
        if (start_edge)
          state_d = (first_pt > last_pt) ? S_DONE : S_SETTLE;
      S_SETTLE:
        if (sweep_abort) state_d = S_IDLE;
        else if (set_cnt == SET_LAST) state_d = S_REQ;
      S_REQ: begin
        meas_req = 1'b1;
        state_d  = sweep_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT:
        if (sweep_abort) state_d = S_IDLE;
        else if (meas_done) begin
          acc_en  = 1'b1;
          state_d = (rep == REP_LAST) ? S_STORE : S_REQ;
        end
`ifdef SWEEP_TIMEOUT_EN
        else if (wd == WD_LAST) begin
          to_hit  = 1'b1;
          state_d = S_STORE;
        end
`endif
      S_STORE:
        if (sweep_abort) state_d = S_IDLE;
        else if (!full || pop) begin
          push    = 1'b1;
          state_d = (addr_q == last_q) ? S_DONE : S_SETTLE;
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) state <= S_IDLE;
    else           state <= state_d;
  end

  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      start_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= '0;
      acc_mod <= '0;
      acc_ph  <= '0;
      rep     <= '0;
      set_cnt <= '0;
    end else begin
      start_q <= sweep_start;
      set_cnt <= (state == S_SETTLE && state_d == S_SETTLE) ?
                 set_cnt + 1'b1 : '0;
      if (state == S_IDLE && start_edge) begin
        last_q  <= last_pt;
        acc_mod <= '0;
        acc_ph  <= '0;
        rep     <= '0;
        if (first_pt <= last_pt) addr_q <= first_pt;
      end
      if (acc_en) begin
        acc_mod <= acc_mod + ACC_W'(signed'(meas_mod));
        acc_ph  <= acc_ph + ACC_W'(signed'(meas_phase));
        if (rep != REP_LAST) rep <= rep + 1'b1;
      end
      // DONE is decided before the increment, so the index never wraps
      if (push && addr_q != last_q) begin
        addr_q  <= addr_q + 1'b1;
        acc_mod <= '0;
        acc_ph  <= '0;
        rep     <= '0;
      end
    end
  end

`ifdef SWEEP_TIMEOUT_EN
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      wd      <= '0;
      to_flag <= 1'b0;
    end else begin
      wd <= (state == S_WAIT && state_d == S_WAIT) ?
            wd + 1'b1 : '0;
      if (state == S_IDLE) to_flag <= 1'b0;
      else if (to_hit)     to_flag <= 1'b1;
      else if (push)       to_flag <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk125) begin
    if (push) begin
      mem_addr[wr_ptr] <= addr_q;
      mem_mod[wr_ptr]  <= push_mod;
      mem_ph[wr_ptr]   <= push_ph;
    end
  end

  // head is masked so the record outputs read 0 while empty
  assign res_addr  = res_valid ? mem_addr[rd_ptr] : '0;
  assign res_mod   = res_valid ? mem_mod[rd_ptr]  : '0;
  assign res_phase = res_valid ? mem_ph[rd_ptr]   : '0;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Bench for sweep_scheduler: engine stub, averaging reference model, record scoreboard.
// Vectors table plus hand sequences for latency, empty range, backpressure, abort.
module tb_sweep_scheduler;

  localparam int AW   = 8;
  localparam int RW   = 32;
  localparam int AL   = 2;
  localparam int ST   = 8;
  localparam int FD   = 4;
  localparam int NREP = 4;
`ifdef SWEEP_TIMEOUT_EN
  localparam int TO   = 64;
`endif

  logic          clk125 = 1'b0;
  logic          areset_n = 1'b0;
  logic          sweep_start = 1'b0;
  logic          sweep_abort = 1'b0;
  logic [AW-1:0] first_pt = '0;
  logic [AW-1:0] last_pt = '0;
  logic          meas_req;
  logic [AW-1:0] meas_addr;
  logic          meas_done;
  logic [RW-1:0] meas_mod;
  logic [RW-1:0] meas_phase;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [AW-1:0] res_addr;
  logic [RW-1:0] res_mod;
  logic [RW-1:0] res_phase;
  logic          busy;
  logic          sweep_done;

  always #4 clk125 = ~clk125;

  sweep_scheduler #(
    .ADDR_WIDTH(AW), .RES_WIDTH(RW), .AVG_LOG2(AL),
    .SETTLE_CYCLES(ST), .FIFO_DEPTH(FD)
`ifdef SWEEP_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk125(clk125), .areset_n(areset_n),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .first_pt(first_pt), .last_pt(last_pt),
    .meas_req(meas_req), .meas_addr(meas_addr),
    .meas_done(meas_done), .meas_mod(meas_mod),
    .meas_phase(meas_phase), .res_valid(res_valid),
    .res_ready(res_ready), .res_addr(res_addr),
    .res_mod(res_mod), .res_phase(res_phase),
    .busy(busy), .sweep_done(sweep_done)
  );

  typedef struct {
    int     addr;
    longint md;
    longint ph;
  } rec_t;

  typedef struct {
    int f, l, md, ph, lat, req, rec;
  } vec_t;

  rec_t   exp_q[$];
  rec_t   hd;
  int     n_cmp = 0, n_fail = 0;
  int     n_req = 0, n_done = 0, n_rec = 0;
  longint last_md = 0, last_ph = 0;

  int     eng_mode = 0, eng_lat = 2;
  int     eng_mod = 0, eng_ph = 0;
  int     seq_mod[4], seq_ph[4];
  int     seq_i = 0;
  bit     model_on = 1'b1;
  bit     mute_en = 1'b0;
  int     mute_addr = 0;
  bit     rnd_ready = 1'b0;
  longint acc_m = 0, acc_p = 0;
  int     cur_n = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // floor(s / NREP), i.e. the averaged value of a point
  function automatic longint fdiv(input longint s);
    longint r;
    r = s % NREP;
    if (r < 0) r += NREP;
    return (s - r) / NREP;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    acc_m = 0;
    acc_p = 0;
    cur_n = 0;
    seq_i = 0;
  endtask

  // engine stub and reference model of the averaged records
  initial begin
    int a, vm, vp;
    meas_done  = 1'b0;
    meas_mod   = '0;
    meas_phase = '0;
    @(posedge clk125); #1;
    forever begin
      while (!meas_req) begin @(posedge clk125); #1; end
      a = int'(meas_addr);
      if (mute_en && a == mute_addr) begin
        if (model_on) begin
          exp_q.push_back('{a, 64'h7FFFFFFF, 0});
          acc_m = 0; acc_p = 0; cur_n = 0;
        end
        @(posedge clk125); #1;
      end else begin
        case (eng_mode)
          0: begin vm = eng_mod; vp = eng_ph; end
          1: begin
            vm = seq_mod[seq_i];
            vp = seq_ph[seq_i];
            seq_i = (seq_i + 1) % 4;
          end
          default: begin vm = $urandom; vp = $urandom; end
        endcase
        repeat (eng_lat) @(posedge clk125);
        #1;
        meas_done  = 1'b1;
        meas_mod   = vm;
        meas_phase = vp;
        @(posedge clk125); #1;
        meas_done = 1'b0;
        if (model_on) begin
          acc_m += vm;
          acc_p += vp;
          cur_n++;
          if (cur_n == NREP) begin
            exp_q.push_back('{a, fdiv(acc_m), fdiv(acc_p)});
            acc_m = 0; acc_p = 0; cur_n = 0;
          end
        end
      end
    end
  end

  always @(negedge clk125) begin
    if (areset_n) begin
      if (meas_req)   n_req++;
      if (sweep_done) n_done++;
    end
  end

  always @(negedge clk125) begin
    if (areset_n && res_valid && res_ready) begin
      n_rec++;
      last_md = $signed(res_mod);
      last_ph = $signed(res_phase);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rec_extra: got addr %0d, expected no record",
                 res_addr);
      end else begin
        hd = exp_q.pop_front();
        chk("rec_addr", longint'(res_addr), hd.addr);
        chk("rec_mod", $signed(res_mod), hd.md);
        chk("rec_phase", $signed(res_phase), hd.ph);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk125); #2;
      if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic do_start(input int f, input int l);
    @(posedge clk125); #1;
    first_pt    = AW'(f);
    last_pt     = AW'(l);
    sweep_start = 1'b1;
    @(posedge clk125); #1;
    sweep_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string nm);
    int c = 0;
    while (n_done == base && c < 4000) begin
      @(posedge clk125); #1;
      c++;
    end
    chk(nm, n_done - base, 1);
  endtask

  task automatic drain(input string nm);
    int c = 0;
    res_ready = 1'b1;
    while (res_valid && c < 300) begin
      @(posedge clk125); #1;
      c++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  vec_t vt[5];

  initial begin
    int bq, br, bd, c, f, len;

    vt[0] = '{10, 12, 100, -8, 50, 12, 3};
    vt[1] = '{0, 0, -5, 7, 3, 4, 1};
    vt[2] = '{253, 255, 1000, -1000, 2, 12, 3};
    vt[3] = '{7, 7, 32'sh7FFFFFFF, 32'sh80000000, 1, 4, 1};
    vt[4] = '{20, 25, -1, 1, 4, 24, 6};

    repeat (3) @(negedge clk125);
    chk("rst_meas_req", meas_req, 0);
    chk("rst_meas_addr", meas_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_addr", res_addr, 0);
    chk("rst_res_mod", res_mod, 0);
    chk("rst_res_phase", res_phase, 0);
    @(posedge clk125); #1;
    areset_n = 1'b1;
    repeat (2) @(posedge clk125);

    for (int i = 0; i < 5; i++) begin
      model_clear();
      eng_mode  = 0;
      eng_mod   = vt[i].md;
      eng_ph    = vt[i].ph;
      eng_lat   = vt[i].lat;
      res_ready = 1'b1;
      bq = n_req; br = n_rec; bd = n_done;
      do_start(vt[i].f, vt[i].l);
      wait_done(bd, $sformatf("v%0d_done", i));
      drain($sformatf("v%0d", i));
      chk($sformatf("v%0d_req", i), n_req - bq, vt[i].req);
      chk($sformatf("v%0d_rec", i), n_rec - br, vt[i].rec);
      chk($sformatf("v%0d_addr", i), meas_addr, vt[i].l);
      chk($sformatf("v%0d_mod", i), last_md, vt[i].md);
      chk($sformatf("v%0d_ph", i), last_ph, vt[i].ph);
    end

    // averaging with truncation toward minus infinity
    model_clear();
    eng_mode = 1;
    eng_lat  = 3;
    seq_mod  = '{1, 2, 3, 5};
    seq_ph   = '{-1, -1, -1, -2};
    bd = n_done;
    do_start(30, 30);
    wait_done(bd, "avg_done");
    drain("avg");
    chk("avg_mod", last_md, 2);
    chk("avg_ph", last_ph, -2);

    // empty range
    model_clear();
    bq = n_req; bd = n_done;
    do_start(5, 4);
    chk("empty_done_t1", sweep_done, 1);
    chk("empty_busy_t1", busy, 0);
    @(posedge clk125); #1;
    chk("empty_done_t2", sweep_done, 0);
    chk("empty_busy_t2", busy, 0);
    repeat (20) @(posedge clk125);
    #1;
    chk("empty_req", n_req - bq, 0);
    chk("empty_done_cnt", n_done - bd, 1);

    // start-to-request latency
    model_clear();
    eng_mode = 0; eng_mod = 3; eng_ph = 4; eng_lat = 2;
    bd = n_done;
    do_start(50, 50);
    chk("lat_busy", busy, 1);
    chk("lat_addr", meas_addr, 50);
    c = 1;
    while (!meas_req && c < 100) begin
      @(posedge clk125); #1;
      c++;
    end
    chk("lat_req_cycle", c, ST + 1);
    @(posedge clk125); #1;
    chk("lat_req_pulse", meas_req, 0);
    wait_done(bd, "lat_done");
    drain("lat");

    // backpressure: full FIFO stalls the sweep in STORE
    model_clear();
    eng_mode = 0; eng_mod = 11; eng_ph = -11; eng_lat = 2;
    res_ready = 1'b0;
    bq = n_req; br = n_rec; bd = n_done;
    do_start(40, 45);
    repeat (400) @(posedge clk125);
    #1;
    chk("bp_req", n_req - bq, 20);
    chk("bp_busy", busy, 1);
    chk("bp_nodone", n_done - bd, 0);
    chk("bp_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_done(bd, "bp_done");
    drain("bp");
    chk("bp_rec", n_rec - br, 6);

    // abort in WAIT with a late meas_done; queued record survives
    model_clear();
    eng_mode = 0; eng_mod = 77; eng_ph = -3; eng_lat = 2;
    res_ready = 1'b0;
    bd = n_done;
    do_start(70, 70);
    wait_done(bd, "ab_pre_done");
    eng_lat = 20;
    br = n_rec; bd = n_done;
    do_start(60, 62);
    c = 0;
    while (!meas_req && c < 100) begin
      @(posedge clk125); #1;
      c++;
    end
    repeat (3) @(posedge clk125);
    #1;
    model_on = 1'b0;
    acc_m = 0; acc_p = 0; cur_n = 0;
    sweep_abort = 1'b1;
    @(posedge clk125); #1;
    sweep_abort = 1'b0;
    chk("ab_busy", busy, 0);
    repeat (40) @(posedge clk125);
    #1;
    chk("ab_fifo_kept", res_valid, 1);
    chk("ab_nodone", n_done - bd, 0);
    model_on = 1'b1;
    drain("ab");
    chk("ab_rec", n_rec - br, 1);
    chk("ab_rec_mod", last_md, 77);
    eng_lat = 3;
    bq = n_req; br = n_rec; bd = n_done;
    do_start(1, 2);
    wait_done(bd, "ab_next_done");
    drain("ab_next");
    chk("ab_next_req", n_req - bq, 8);
    chk("ab_next_rec", n_rec - br, 2);

    // random values, latency and consumer readiness
    for (int r = 0; r < 4; r++) begin
      model_clear();
      f   = $urandom_range(0, 250);
      len = $urandom_range(0, 3);
      eng_mode  = 2;
      eng_lat   = $urandom_range(1, 8);
      rnd_ready = 1'b1;
      bq = n_req; br = n_rec; bd = n_done;
      do_start(f, f + len);
      wait_done(bd, $sformatf("rnd%0d_done", r));
      rnd_ready = 1'b0;
      drain($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_req", r), n_req - bq, 4 * (len + 1));
      chk($sformatf("rnd%0d_rec", r), n_rec - br, len + 1);
    end

`ifdef SWEEP_TIMEOUT_EN
    // mute engine on one point: sentinel record, sweep continues
    model_clear();
    eng_mode = 0; eng_mod = 9; eng_ph = 9; eng_lat = 2;
    mute_en = 1'b1; mute_addr = 3;
    res_ready = 1'b1;
    bq = n_req; br = n_rec; bd = n_done;
    do_start(2, 4);
    wait_done(bd, "to_done");
    drain("to");
    mute_en = 1'b0;
    chk("to_req", n_req - bq, 9);
    chk("to_rec", n_rec - br, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
